// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier with a start/busy/done handshake.
// One WIDTH+1-bit adder is reused over WIDTH clock cycles to form a 2*WIDTH-bit
// product. In signed mode the operands are reduced to magnitudes on entry. The
// sign is reapplied to the product as it is written into data_out.
module seq_multiplier #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode_signed,
    input  logic [WIDTH-1:0]     data_A,
    input  logic [WIDTH-1:0]     data_B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   data_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    // Upper half holds the running accumulator; lower half holds the multiplier
    // bits that have not been consumed yet.
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   data_out_q, data_out_d;

    logic                 op_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       partial_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic [2*WIDTH-1:0]   final_result;

    // Operand conditioning: magnitudes of the incoming operands. -2^(W-1) maps onto itself and stays correct as an unsigned magnitude.
    always_comb begin
        op_signed = SIGNED_EN && mode_signed;
        mag_a     = data_A;
        mag_b     = data_B;
        if (op_signed && data_A[WIDTH-1]) begin
            mag_a = ~data_A + ONE_W;
        end
        if (op_signed && data_B[WIDTH-1]) begin
            mag_b = ~data_B + ONE_W;
        end
    end

    // One shift-add step: conditionally add the multiplicand with carry kept, then shift the whole register right.
    always_comb begin
        addend       = prod_q[0] ? mcand_q : '0;
        partial_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod_step    = {partial_sum, prod_q[WIDTH-1:1]};
        final_result = neg_q ? (~prod_step + ONE_2W) : prod_step;
    end

    // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    mcand_d = mag_a;
                    prod_d  = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = '0;
                    neg_d   = op_signed && (data_A[WIDTH-1] ^ data_B[WIDTH-1]);
                end
            end
            CALC: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + ONE_C;
                if (cnt_q == LAST_ITER) begin
                    state_d    = DONE;
                    data_out_d = final_result;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, including data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            data_out_q <= data_out_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = data_out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: drives seq_multiplier (WIDTH=8, signed mode enabled) with directed and
// random operations. Every cycle, the outputs are compared against a cycle-count
// reference model that is built from plain integer arithmetic.
module tb_seq_multiplier;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 mode_signed;
    logic [WIDTH-1:0]     data_A;
    logic [WIDTH-1:0]     data_B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   data_out;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    seq_multiplier #(.WIDTH(WIDTH), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode_signed (mode_signed),
        .data_A      (data_A),
        .data_B      (data_B),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact product computed with plain integer arithmetic and truncated to 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] refProduct(input bit ms, input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        int p;
        int sa;
        int sb;
        if (ms) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        p = sa * sb;
        return p[2*WIDTH-1:0];
    endfunction

    // Reference model. After an accepted start, the unit stays busy for WIDTH+1 cycles.
    // The last of those cycles is the done cycle, and the new result appears there.
    int                 mCnt = 0;
    logic [2*WIDTH-1:0] mPend = '0;
    logic [2*WIDTH-1:0] mOut = '0;

    always @(posedge clk) begin
        if (rst) begin
            mCnt <= 0;
            mOut <= '0;
        end else if (mCnt == 0) begin
            if (start) begin
                mCnt  <= WIDTH + 1;
                mPend <= refProduct(mode_signed, data_A, data_B);
            end
        end else begin
            mCnt <= mCnt - 1;
            if (mCnt == 2) mOut <= mPend;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare the outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", {31'b0, busy}, {31'b0, (mCnt != 0)});
            checkOutput("done", {31'b0, done}, {31'b0, (mCnt == 1)});
            checkOutput("data_out", {16'b0, data_out}, {16'b0, mOut});
        end
    end

    task automatic applyStimulus(input bit st, input bit ms, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        @(posedge clk);
        #1;
        start       = st;
        mode_signed = ms;
        data_A      = a;
        data_B      = b;
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got no done expected done within 40 cycles", name);
    endtask

    // One full operation: start for a single edge, then scramble the inputs while busy.
    // Checks the latency, the busy length and the result.
    task automatic runOp(input bit ms, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] expected, input string name);
        int busyCnt = 0;
        int k;
        bit seen = 1'b0;
        applyStimulus(1'b1, ms, a, b);
        applyStimulus(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            timeoutFail(name);
        end else begin
            checkOutput("latency", k, WIDTH);
            checkOutput("busyCycles", busyCnt, WIDTH + 1);
            checkOutput(name, {16'b0, data_out}, {16'b0, expected});
        end
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeoutFail(name);
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int nDone;
        int idx;
        int d1;
        int d2;
        bit holdBad;
        bit ms;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst = 1'b1;
        start = 1'b0;
        mode_signed = 1'b0;
        data_A = '0;
        data_B = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetOut", {16'b0, data_out}, 32'd0);
        checkEn = 1'b1;

        // Hand-computed values that pin the reference function itself.
        checkOutput("refSigned", {16'b0, refProduct(1'b1, 8'hFD, 8'h05)}, 32'h0000FFF1);
        checkOutput("refUnsigned", {16'b0, refProduct(1'b0, 8'hFD, 8'h05)}, 32'h000004F1);
        checkOutput("refCorner", {16'b0, refProduct(1'b1, 8'h80, 8'h80)}, 32'h00004000);

        $display("[TB] directed operations");
        runOp(1'b0, 8'hFF, 8'hFF, 16'hFE01, "unsignedMax");
        runOp(1'b1, 8'hFD, 8'h05, 16'hFFF1, "signedMixed");
        runOp(1'b0, 8'hFD, 8'h05, 16'h04F1, "sameBitsUnsigned");
        runOp(1'b1, 8'h80, 8'h80, 16'h4000, "signedMinSquared");
        runOp(1'b1, 8'h80, 8'h01, 16'hFF80, "signedMinTimesOne");
        runOp(1'b1, 8'h00, 8'h9C, 16'h0000, "zeroOperand");

        $display("[TB] start while busy");
        applyStimulus(1'b1, 1'b0, 8'd3, 8'd4);
        applyStimulus(1'b0, 1'b0, 8'd3, 8'd4);
        applyStimulus(1'b0, 1'b0, 8'd3, 8'd4);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
        applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF);
        waitDone("busyStartDone");
        checkOutput("busyStartOut", {16'b0, data_out}, 32'h0000000C);
        countDones(14, nDone);
        checkOutput("busyStartExtraDone", nDone, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h10);
        applyStimulus(1'b0, 1'b0, 8'h10, 8'h10);
        applyStimulus(1'b0, 1'b0, 8'h10, 8'h10);
        applyStimulus(1'b0, 1'b0, 8'h10, 8'h10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortDone", {31'b0, done}, 32'd0);
        checkOutput("abortOut", {16'b0, data_out}, 32'd0);
        countDones(14, nDone);
        checkOutput("abortNoDone", nDone, 0);
        runOp(1'b0, 8'd2, 8'd7, 16'h000E, "afterAbort");

        $display("[TB] back-to-back with start held");
        applyStimulus(1'b1, 1'b0, 8'd6, 8'd7);
        applyStimulus(1'b1, 1'b0, 8'd0, 8'h55);
        idx = 0;
        d1 = -1;
        d2 = -1;
        holdBad = 1'b0;
        while (idx < 60 && d2 < 0) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = idx;
                    checkOutput("b2bFirst", {16'b0, data_out}, 32'h0000002A);
                end else begin
                    d2 = idx;
                end
            end else if (d1 >= 0 && data_out !== 16'h002A) begin
                holdBad = 1'b1;
            end
            idx++;
        end
        if (d2 < 0) begin
            timeoutFail("b2bSecondDone");
        end else begin
            checkOutput("b2bGap", d2 - d1, WIDTH + 2);
            checkOutput("b2bSecond", {16'b0, data_out}, 32'h00000000);
            checkOutput("b2bHold", {31'b0, holdBad}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            ms = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) a = 8'h80;
            if ($urandom_range(0, 5) == 0) b = 8'hFF;
            runOp(ms, a, b, refProduct(ms, a, b), "randomProduct");
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends, even if the handshake locks up.
    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got no completion expected completion by 200000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
